// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone BRAM arbiter.
// Holds the grant state encoding, default bus widths and the saturating
// counter helpers used by the arbiter top.
package wb_arb_pkg;

  localparam int ARB_AW_DEFAULT      = 8;
  localparam int ARB_DW_DEFAULT      = 8;
  localparam int ARB_TIMEOUT_DEFAULT = 16;

  // Accepted-but-unacknowledged request count.
  localparam int OUTSTANDING_W = 4;
  // Acks still owed for an aborted cycle; one bit wider so two quick
  // aborts in a row cannot wrap.
  localparam int STALE_W = OUTSTANDING_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  typedef logic [OUTSTANDING_W-1:0] outstanding_t;
  typedef logic [STALE_W-1:0]       stale_t;

  // One step of the outstanding counter: +1 on accept, -1 on ack,
  // unchanged when both or neither happen; saturates at both ends.
  function automatic outstanding_t outstanding_step(input outstanding_t cur,
                                                    input logic         inc,
                                                    input logic         dec);
    outstanding_t res;
    res = cur;
    if (inc && !dec) begin
      if (cur != '1) res = cur + outstanding_t'(1);
    end else if (dec && !inc) begin
      if (cur != '0) res = cur - outstanding_t'(1);
    end
    return res;
  endfunction

  // Saturating add of an aborted cycle's remaining acks onto the stale count.
  function automatic stale_t stale_add(input stale_t cur, input outstanding_t add);
    logic [STALE_W:0] sum;
    sum = {1'b0, cur} + {{(STALE_W + 1 - OUTSTANDING_W){1'b0}}, add};
    if (sum[STALE_W]) return '1;
    return sum[STALE_W-1:0];
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Ack watchdog for the Wishbone arbiter. Counts cycles spent waiting for an
// ack while requests are outstanding; when the wait reaches TIMEOUT cycles it
// raises a one-cycle error and, on the following cycle, a one-cycle force
// strobe that the arbiter uses to drop s_cyc and release the grant.
// Only instantiated when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_run,
  input  logic i_pending,
  input  logic i_ack,
  output logic o_err,
  output logic o_force
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;
  logic          r_force;

  // The error fires in the TIMEOUT-th cycle of waiting, unless an ack shows
  // up in that very cycle; it is suppressed during the force cycle itself.
  assign o_err   = i_pending && !i_ack && !r_force && (r_cnt == LIMIT);
  assign o_force = r_force;

  // Wait counter and the delayed force strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_force <= 1'b0;
    end else if (i_run) begin
      r_force <= o_err;
      if (o_err || r_force || i_ack || !i_pending) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/wb_dpbram_arbiter.sv
// Two-master round-robin arbiter for Wishbone B4 pipelined buses, placed in
// front of one port of a dual-port BRAM. Ownership is granted per cyc
// envelope; the owner's request lines drive the slave port and only the owner
// sees stall/ack/rdata. Acks belonging to an aborted cycle (owner dropped cyc
// with requests still outstanding) are swallowed so the next owner never
// receives them.
// Optional ack timeout watchdog: define WB_ARB_TIMEOUT_EN.
module wb_dpbram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW      = ARB_AW_DEFAULT,
  parameter int DW      = ARB_DW_DEFAULT,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  // master 0
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_stall,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  // master 1
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_stall,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  // BRAM slave port
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic          s_stall,
  input  logic          s_ack,
  input  logic [DW-1:0] s_rdata
);

  arb_state_t   r_state;
  arb_state_t   w_state_next;
  logic         r_last;
  logic         w_last_next;
  logic         r_run;
  outstanding_t r_out;
  outstanding_t w_out_next;
  outstanding_t w_abort_left;
  stale_t       r_stale;
  stale_t       w_stale_dec;
  stale_t       w_stale_next;
  logic         w_accept;
  logic         w_ack_live;
  logic         w_abort;
  logic         w_err;
  logic         w_force;

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_run     (r_run),
    .i_pending (r_out != '0),
    .i_ack     (s_ack),
    .o_err     (w_err),
    .o_force   (w_force)
  );
`else
  // No error source without the watchdog; the comparison is always false and
  // only keeps TIMEOUT referenced in this build.
  assign w_err   = (TIMEOUT < 0);
  assign w_force = 1'b0;
`endif

  // An ack is live (belongs to the current owner) only once every ack owed to
  // an earlier aborted cycle has been swallowed; the slave never reorders.
  assign w_ack_live = s_ack && (r_stale == '0);
  assign w_accept   = s_stb && !s_stall;

  // Route the owner's request to the slave and the slave's response back to
  // the owner only; a non-owner always sees stall=1, ack=0, rdata=0.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    m0_stall = 1'b1;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = '0;
    m1_stall = 1'b1;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = '0;
    case (r_state)
      OWN0: begin
        if (!w_force) begin
          s_cyc    = m0_cyc;
          s_stb    = m0_stb && m0_cyc;
          s_we     = m0_we;
          s_addr   = m0_addr;
          s_wdata  = m0_wdata;
          m0_stall = s_stall;
        end
        m0_ack   = w_ack_live;
        m0_rdata = s_rdata;
        m0_err   = w_err;
      end
      OWN1: begin
        if (!w_force) begin
          s_cyc    = m1_cyc;
          s_stb    = m1_stb && m1_cyc;
          s_we     = m1_we;
          s_addr   = m1_addr;
          s_wdata  = m1_wdata;
          m1_stall = s_stall;
        end
        m1_ack   = w_ack_live;
        m1_rdata = s_rdata;
        m1_err   = w_err;
      end
      default: ;
    endcase
  end

  // Grant selection: round-robin on ties, hold while the owner keeps cyc,
  // hand over back-to-back on release (or watchdog force).
  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    case (r_state)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          w_state_next = r_last ? OWN0 : OWN1;
        end else if (m0_cyc) begin
          w_state_next = OWN0;
        end else if (m1_cyc) begin
          w_state_next = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc || w_force) begin
          w_last_next  = 1'b0;
          w_state_next = m1_cyc ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_cyc || w_force) begin
          w_last_next  = 1'b1;
          w_state_next = m0_cyc ? OWN0 : IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Outstanding and stale-ack bookkeeping. Whenever s_cyc is low the
  // outstanding count is cleared; if it was non-zero the cycle was aborted
  // and its remaining acks move to the stale count to be discarded.
  always_comb begin
    w_abort      = !s_cyc && (r_out != '0);
    w_abort_left = w_ack_live ? (r_out - outstanding_t'(1)) : r_out;
    w_stale_dec  = (s_ack && (r_stale != '0)) ? (r_stale - stale_t'(1)) : r_stale;

    if (!s_cyc) begin
      w_out_next = '0;
    end else begin
      w_out_next = outstanding_step(r_out, w_accept, w_ack_live);
    end

    if (w_force) begin
      // A timed-out slave is assumed to have dropped its pending requests.
      w_stale_next = '0;
    end else if (w_abort) begin
      w_stale_next = stale_add(w_stale_dec, w_abort_left);
    end else begin
      w_stale_next = w_stale_dec;
    end
  end

  // Reset deassertion is retimed through one flop so the arbiter leaves
  // reset on a clock edge rather than at an arbitrary point in the cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Grant, round-robin history and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_out   <= '0;
      r_stale <= '0;
    end else if (r_run) begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
      r_out   <= w_out_next;
      r_stale <= w_stale_next;
    end
  end

endmodule

// File: doc/wb_dpbram_arbiter.md
Name: wb_dpbram_arbiter

Overview:
- Two-master round-robin arbiter for Wishbone B4 pipelined buses. Shares one port of the dual-port BRAM between two requesters, e.g. a CPU data bus and a DMA engine.
- Grants bus ownership per Wishbone cycle (cyc envelope). Routes stb/we/addr/data to the BRAM port and returns ack/data to the owner only.
- Sits directly in front of the BRAM slave port, in the same clk domain.

Parameters:
- AW, 8, address width
- DW, 8, data width
- TIMEOUT, 16, cycles without ack before abort (used only with the optional feature)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle, strobe, write-enable
- m0_addr  in  AW  master 0 address
- m0_wdata  in  DW  master 0 write data
- m0_stall  out  1  master 0 stall
- m0_ack  out  1  master 0 acknowledge
- m0_err  out  1  master 0 error
- m0_rdata  out  DW  master 0 read data
- m1_*  same set as m0_*  master 1
- s_cyc, s_stb, s_we  out  1 each  to BRAM port
- s_addr  out  AW  to BRAM port
- s_wdata  out  DW  to BRAM port
- s_stall  in  1  from BRAM port
- s_ack  in  1  from BRAM port
- s_rdata  in  DW  from BRAM port

Behaviour:
- Reset (async assert, sync release): state=IDLE, last=1 (so master 0 wins the first tie), outstanding=0.
  - s_cyc=s_stb=s_we=0; s_addr=s_wdata=0.
  - m*_stall=1, m*_ack=0, m*_err=0, m*_rdata=0.
- FSM states: IDLE, OWN0, OWN1; grant is registered.
  - IDLE: m0_cyc only -> OWN0. m1_cyc only -> OWN1. Both -> owner is !last.
  - OWNn: stays while mn_cyc=1.
  - When mn_cyc=0: go to OWN(other) if other cyc=1, else IDLE; set last=n.
  - Switching between owners is back-to-back; no idle cycle.
- Latency: grant is visible one cycle after the request cycle. While not owner, a master sees stall=1, ack=0.
- Routing (combinational from state):
  - Owner's cyc/stb/we/addr/wdata drive s_*.
  - Owner's stall = s_stall.
  - Owner's ack = s_ack, rdata = s_rdata.
  - Non-owner: ack=0, rdata=0.
  - In IDLE, s_cyc=s_stb=0.
- Outstanding counter, 4 bits, saturating at 15:
  - +1 on s_stb&!s_stall; -1 on s_ack; both in the same cycle -> unchanged.
  - Cleared when s_cyc falls.
- Owner drops cyc with outstanding>0: treated as abort. Late s_ack for it is discarded (routed to nobody); counter cleared.
- Simultaneous owner-release and other-request: release wins that cycle; next cycle the other master owns the bus.
- Acks are never re-ordered or duplicated. One s_ack maps to exactly one owner ack.
- Reset mid-cycle: immediate return to reset values. Transactions in flight are lost.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle with outstanding>0 and s_ack=0, and resets on any s_ack.
  - At TIMEOUT the owner gets a single-cycle err=1 and s_cyc is forced to 0 for one cycle.
  - The grant is then released per normal release rules and outstanding is cleared.
- Undefined: no counter; m0_err and m1_err are constant 0.

Decomposition:
- Package wb_arb_pkg holds:
  - state enum arb_state_t {IDLE, OWN0, OWN1}
  - default AW/DW localparams
  - OUTSTANDING_W=4
- One natural sub-module: wb_arb_watchdog (timeout counter plus err pulse). Instantiated only under WB_ARB_TIMEOUT_EN.

Test Plan:
- Reset with m0_cyc=1 held -> all outputs at reset values; after release, m0 is granted on the 2nd edge and m1_stall stays 1.
- m0 write addr 0x12 data 0xA5, then read 0x12 -> m0_ack once per stb; m0_rdata=0xA5; m1_ack stays 0 throughout.
- m0 and m1 assert cyc in the same cycle, 3 times in a row (each drops cyc after 1 access) -> grant sequence 0,1,0 with no IDLE gap between owners.
- m0 issues 4 pipelined reads with s_stall=1 on the 2nd -> exactly 4 m0_ack; m0_stall mirrors s_stall.
- m0 drops cyc with 2 outstanding, then m1 owns the bus and the slave returns a late ack -> m1_ack=0 for that stale ack.
- WB_ARB_TIMEOUT_EN, slave never acks, TIMEOUT=16 -> m0_err=1 exactly 16 cycles after the stb; s_cyc=0 the next cycle; m1 granted if requesting.
